seg7_capture: RTL and testbench

Receive-side monitor for the 7-segment display bus: samples one 8-bit active-high segment word (bits [7:1] segments, bit 0 decimal point), requires the pattern to be stable for a programmable number of cycles, decodes it back to a hex digit, and reports each change as an event over a valid/ready handshake. It sits on the display pins for self-check and debug readback, recovering the digit that the hex-to-segment encoder is showing.

---
 rtl/seg7_capture_if.sv | 23 ++
 rtl/seg7_capture.sv | 144 ++++++++++++++
 tb/tb_seg7_capture.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: the segment bus that is observed, and the event handshake.
//   slave  modport: used by the monitor (seg_i/ready_i/ovf_clr_i in, event outputs out)
//   master modport: used by whatever drives the display pins and consumes events
interface seg7_capture_if;
  logic [7:0] seg_i;
  logic       ready_i;
  logic       ovf_clr_i;
  logic       valid_o;
  logic [3:0] digit_o;
  logic       dp_o;
  logic       err_o;
  logic       ovf_o;

  modport slave (
    input  seg_i, ready_i, ovf_clr_i,
    output valid_o, digit_o, dp_o, err_o, ovf_o
  );

  modport master (
    output seg_i, ready_i, ovf_clr_i,
    input  valid_o, digit_o, dp_o, err_o, ovf_o
  );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: debounces a 7-segment display word, decodes it back to a hex
// digit and reports each change as an event over valid/ready.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus (slave)   : seg_i observed word, ready_i/valid_o handshake,
//                   digit_o/dp_o/err_o event payload, ovf_o sticky drop flag
//                   cleared by ovf_clr_i
// Optional feature: define SEG7_CAPTURE_ERR_EN to report stable non-blank
// patterns that match no hex digit (err_o=1, digit_o=0).
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  seg7_capture_if.slave  bus
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

`ifdef SEG7_CAPTURE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [7:0]   seg_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]   last_q;
  logic         none_q;

  logic         same_c;
  logic         accept_c;
  logic         blank_c;
  logic         match_c;
  logic [3:0]   digit_c;
  logic         ev_c;
  logic         load_c;

  assign same_c = (bus.seg_i == seg_q);

  // Input sample and saturating stability counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_q <= 8'h00;
      cnt_q <= '0;
    end else begin
      seg_q <= bus.seg_i;
      if (!same_c)
        cnt_q <= '0;
      else if (cnt_q != CW'(STABLE_CYCLES))
        cnt_q <= cnt_q + CW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= TRACK;
    else       state_q <= state_d;
  end

  // Acceptance fires on the edge where the count reaches the threshold
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      TRACK: begin
        if (same_c && (cnt_q == CW'(STABLE_CYCLES - 1))) begin
          accept_c = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!same_c) state_d = TRACK;
      end
      default: state_d = TRACK;
    endcase
  end

  // Segment-to-hex decode; bit 0 (decimal point) is ignored
  always_comb begin
    match_c = 1'b1;
    digit_c = 4'h0;
    case ({seg_q[7:1], 1'b0})
      8'h7E: digit_c = 4'h0;
      8'h12: digit_c = 4'h1;
      8'hBC: digit_c = 4'h2;
      8'hB6: digit_c = 4'h3;
      8'hD2: digit_c = 4'h4;
      8'hE6: digit_c = 4'h5;
      8'hEE: digit_c = 4'h6;
      8'h32: digit_c = 4'h7;
      8'hFE: digit_c = 4'h8;
      8'hF2: digit_c = 4'h9;
      8'hFA: digit_c = 4'hA;
      8'hCE: digit_c = 4'hB;
      8'h6C: digit_c = 4'hC;
      8'h9E: digit_c = 4'hD;
      8'hEC: digit_c = 4'hE;
      8'hE8: digit_c = 4'hF;
      default: match_c = 1'b0;
    endcase
  end

  assign blank_c = (seg_q[7:1] == 7'h00);
  assign ev_c    = accept_c && !blank_c && (match_c || ERR_EN) &&
                   (none_q || (seg_q != last_q));
  assign load_c  = !bus.valid_o || bus.ready_i;

  // Event output register, last-reported tracking and overflow flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.valid_o <= 1'b0;
      bus.digit_o <= 4'h0;
      bus.dp_o    <= 1'b0;
      bus.err_o   <= 1'b0;
      bus.ovf_o   <= 1'b0;
      last_q      <= 8'h00;
      none_q      <= 1'b1;
    end else begin
      if (bus.valid_o && bus.ready_i)
        bus.valid_o <= 1'b0;
      if (bus.ovf_clr_i)
        bus.ovf_o <= 1'b0;
      // Blank forgets history so a repeated digit is reported again
      if (accept_c && blank_c)
        none_q <= 1'b1;
      if (ev_c) begin
        if (load_c) begin
          bus.valid_o <= 1'b1;
          bus.digit_o <= match_c ? digit_c : 4'h0;
          bus.dp_o    <= seg_q[0];
          bus.err_o   <= ERR_EN && !match_c;
          last_q      <= seg_q;
          none_q      <= 1'b0;
        end else begin
          bus.ovf_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: randomized and directed stimulus against a behavioural
// model built from run lengths of identical samples and a table lookup.
module tb_seg7_capture;

  localparam int unsigned S = 4;

`ifdef SEG7_CAPTURE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_capture_if bus ();

  seg7_capture #(.STABLE_CYCLES(S)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs  = 0;

  logic [7:0] tbl [16] = '{8'h7E, 8'h12, 8'hBC, 8'hB6, 8'hD2, 8'hE6, 8'hEE, 8'h32,
                           8'hFE, 8'hF2, 8'hFA, 8'hCE, 8'h6C, 8'h9E, 8'hEC, 8'hE8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: state of the expected outputs after each edge
  bit         m_valid, m_dp, m_err, m_ovf, m_none;
  logic [3:0] m_digit;
  logic [7:0] m_prev, m_last;
  int         m_run;

  function automatic int lookup(input logic [7:0] v);
    for (int i = 0; i < 16; i++)
      if (tbl[i][7:1] == v[7:1]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit can_load;
    int d;
    if (rst) begin
      m_valid = 0; m_digit = 0; m_dp = 0; m_err = 0; m_ovf = 0;
      m_prev = 8'h00; m_run = 1; m_none = 1; m_last = 8'h00;
    end else begin
      m_run    = (bus.seg_i == m_prev) ? m_run + 1 : 1;
      m_prev   = bus.seg_i;
      can_load = !m_valid || bus.ready_i;
      if (m_valid && bus.ready_i) m_valid = 0;
      if (bus.ovf_clr_i) m_ovf = 0;
      if (m_run == S + 1) begin
        d = lookup(m_prev);
        if (m_prev[7:1] == 7'h00) begin
          m_none = 1;
        end else if ((d >= 0 || ERR_EN) && (m_none || m_prev != m_last)) begin
          if (can_load) begin
            m_valid = 1;
            m_digit = (d < 0) ? 4'h0 : 4'(d);
            m_dp    = m_prev[0];
            m_err   = (d < 0);
            m_last  = m_prev;
            m_none  = 0;
          end else begin
            m_ovf = 1;
          end
        end
      end
    end
  end

  // One clock: compare all outputs just after the edge, count handshakes
  task automatic tick();
    @(posedge clk);
    #1;
    check("outs", 32'({bus.valid_o, bus.digit_o, bus.dp_o, bus.err_o, bus.ovf_o}),
                  32'({m_valid, m_digit, m_dp, m_err, m_ovf}));
    if (bus.valid_o && bus.ready_i) n_hs++;
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    bus.seg_i = v;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int h;
    logic [7:0] v;
    bus.seg_i = 8'h00; bus.ready_i = 1'b1; bus.ovf_clr_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_valid", 32'(bus.valid_o), 32'd0);

    // Basic decode: one event after E0+S, none while held
    n_hs = 0;
    bus.seg_i = 8'hB6;
    for (int i = 0; i < S; i++) begin
      tick();
      check("early_valid", 32'(bus.valid_o), 32'd0);
    end
    tick();
    check("basic_valid", 32'(bus.valid_o), 32'd1);
    check("basic_digit", 32'(bus.digit_o), 32'd3);
    hold(8'hB6, 100);
    check("basic_count", 32'(n_hs), 32'd1);

    // Glitch filter
    n_hs = 0;
    hold(8'hFE, 3);
    hold(8'h7E, 20);
    check("glitch_count", 32'(n_hs), 32'd1);
    hold(8'h7F, 10);
    check("dp_count", 32'(n_hs), 32'd2);
    check("dp_bit", 32'(bus.dp_o), 32'd1);

    // Blank and repeat
    n_hs = 0;
    hold(8'h12, 10);
    hold(8'h00, 10);
    hold(8'h12, 10);
    hold(8'hFE, 2);
    hold(8'h12, 10);
    check("blank_repeat", 32'(n_hs), 32'd2);

    // Backpressure, drop, set-over-clear
    bus.ready_i = 1'b0;
    hold(8'hFA, 8);
    hold(8'hE8, 8);
    check("bp_digit", 32'(bus.digit_o), 32'hA);
    check("bp_ovf", 32'(bus.ovf_o), 32'd1);
    bus.ready_i = 1'b1;
    hold(8'hE8, 3);
    check("bp_drain", 32'(bus.valid_o), 32'd0);
    bus.ovf_clr_i = 1'b1; tick(); bus.ovf_clr_i = 1'b0;
    check("ovf_clr", 32'(bus.ovf_o), 32'd0);
    bus.ready_i = 1'b0;
    hold(8'hEE, 8);
    bus.seg_i = 8'hCE;
    for (int i = 0; i < S; i++) tick();
    bus.ovf_clr_i = 1'b1; tick(); bus.ovf_clr_i = 1'b0;
    check("set_wins", 32'(bus.ovf_o), 32'd1);
    bus.ready_i = 1'b1;
    hold(8'hE8, 8);
    check("reaccept", 32'(bus.digit_o), 32'hF);

    // Error path
    n_hs = 0;
    hold(8'h02, 10);
    check("err_count", 32'(n_hs), ERR_EN ? 32'd1 : 32'd0);

    // Reset mid-operation
    bus.ready_i = 1'b0;
    hold(8'h12, 8);
    hold(8'hB6, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid", 32'({bus.valid_o, bus.digit_o, bus.ovf_o}), 32'd0);
    bus.ready_i = 1'b1;
    hold(8'h12, 8);
    check("rst_rereport", 32'(bus.digit_o), 32'd1);

    // Randomized phase
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0:       v = 8'h00;
        1:       v = 8'h02;
        2:       v = 8'($urandom);
        default: v = tbl[$urandom_range(0, 15)] | 8'($urandom_range(0, 1));
      endcase
      h = $urandom_range(1, 10);
      bus.seg_i = v;
      for (int i = 0; i < h; i++) begin
        bus.ready_i   = ($urandom_range(0, 3) != 0);
        bus.ovf_clr_i = ($urandom_range(0, 19) == 0);
        rst           = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    rst = 1'b0; bus.ovf_clr_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
